// File: rtl/booth_mult_pkg.sv
// ============================================================================
//  Module      : booth_mult_pkg
//  Description : Shared types and helpers for the radix-4 Booth multiplier:
//                digit encoding, recoder and CSA tree sizing functions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_mult_pkg;

    // One-hot magnitude with separate sign: {neg, two, one}
    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_digit_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int NDIG          = DEFAULT_WIDTH / 2 + 1;
    localparam int PPW           = DEFAULT_WIDTH + 2;

    function automatic int ndig_of(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int ppw_of(input int width);
        return width + 2;
    endfunction

    // Window is {b[2i+1], b[2i], b[2i-1]}; all-ones decodes to a plain zero
    // so a negated zero never reaches the tree.
    function automatic booth_digit_t booth_recode(input logic [2:0] win);
        booth_digit_t d;
        d = '0;
        case (win)
            3'b001, 3'b010: d.one = 1'b1;
            3'b011:         d.two = 1'b1;
            3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
            3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
            default:        d = '0;
        endcase
        return d;
    endfunction

    function automatic int csa_rows_after(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int csa_rows_at(input int n0, input int lvl);
        int n;
        n = n0;
        for (int k = 0; k < lvl; k++) n = csa_rows_after(n);
        return n;
    endfunction

    function automatic int csa_levels(input int n0);
        int n;
        int l;
        n = n0;
        l = 0;
        while (n > 2) begin
            n = csa_rows_after(n);
            l++;
        end
        return l;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_mult_pipe_pp_row.sv
// ============================================================================
//  Module      : booth_pp_row
//  Description : One Booth digit times the multiplicand -> signed PPW-bit row
//                (ones' complement when negative) plus its negate bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_pp_row
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  booth_digit_t       digit,
    input  logic [WIDTH-1:0]   a,
    input  logic               a_signed,
    output logic [WIDTH+1:0]   row,
    output logic               neg
);

    localparam int c_ppw = ppw_of(WIDTH);

    logic [c_ppw-1:0] w_a_ext;
    logic [c_ppw-1:0] w_mag;

    assign w_a_ext = {{2{a_signed & a[WIDTH-1]}}, a};

    always_comb begin
        w_mag = '0;
        if (digit.one)
            w_mag = w_a_ext;
        else if (digit.two)
            w_mag = {w_a_ext[c_ppw-2:0], 1'b0};
    end

    // The +1 of the two's complement is carried separately as the negate bit
    assign row = digit.neg ? ~w_mag : w_mag;
    assign neg = digit.neg;

endmodule

`default_nettype wire

// File: rtl/booth_mult_pipe.sv
// ============================================================================
//  Module      : booth_mult_pipe
//  Description : Three-stage valid/ready radix-4 Booth multiplier,
//                WIDTH x WIDTH -> 2*WIDTH, per-beat signed/unsigned mode.
//                Define BOOTH_MULT_ACC_EN to add the in_c addend port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_mult_pipe
    import booth_mult_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
`ifdef BOOTH_MULT_ACC_EN
    input  logic [2*WIDTH-1:0]   in_c,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int c_pw   = 2 * WIDTH;
    localparam int c_ndig = ndig_of(WIDTH);
    localparam int c_ppw  = ppw_of(WIDTH);
`ifdef BOOTH_MULT_ACC_EN
    localparam int c_nrows = c_ndig + 3;
`else
    localparam int c_nrows = c_ndig + 2;
`endif
    localparam int c_nlev = csa_levels(c_nrows);

    if (WIDTH < 4 || WIDTH > 32 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("booth_mult_pipe: WIDTH must be even and within 4..32");
    end

    // Each row enters as {~s, low bits}; the -2^(PPW-1) owed per row is
    // folded into this single constant row.
    function automatic logic [c_pw-1:0] sign_corr(input int ndig);
        logic [c_pw-1:0] acc;
        logic [c_pw-1:0] one;
        acc = '0;
        one = {{(c_pw-1){1'b0}}, 1'b1};
        for (int i = 0; i < ndig; i++)
            acc = acc - (one << (c_ppw - 1 + 2 * i));
        return acc;
    endfunction

    localparam logic [c_pw-1:0] c_sign_corr = sign_corr(c_ndig);

    logic w_ld1, w_ld2, w_ld3;

    logic                r_v1, r_v2, r_v3;
    logic [WIDTH-1:0]    r_a1, r_b1;
    logic                r_sgn1;
`ifdef BOOTH_MULT_ACC_EN
    logic [c_pw-1:0]     r_c1;
`endif
    logic [c_pw-1:0]     r_sum2, r_cry2;
    logic [c_pw-1:0]     r_p3;

    assign w_ld3    = ~r_v3 | out_ready;
    assign w_ld2    = ~r_v2 | w_ld3;
    assign w_ld1    = ~r_v1 | w_ld2;
    assign in_ready = w_ld1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_ld1) r_v1 <= in_valid;
            if (w_ld2) r_v2 <= r_v1;
            if (w_ld3) r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld1 && in_valid) begin
            r_a1   <= in_a;
            r_b1   <= in_b;
            r_sgn1 <= in_signed;
`ifdef BOOTH_MULT_ACC_EN
            r_c1   <= in_c;
`endif
        end
    end

    // ---------------- S2: recode, partial products, CSA tree -------------
    logic [WIDTH+2:0]   w_b_win;
    logic [c_ppw-1:0]   w_pp [c_ndig];
    logic [c_ndig-1:0]  w_neg;
    logic [c_pw-1:0]    w_rows [c_nrows];
    logic [c_pw-1:0]    w_negrow;
    logic [c_pw-1:0]    w_lvl [c_nlev+1][c_nrows];

    assign w_b_win = {{2{r_sgn1 & r_b1[WIDTH-1]}}, r_b1, 1'b0};

    for (genvar i = 0; i < c_ndig; i++) begin : g_digit
        booth_digit_t w_dig;
        assign w_dig = booth_recode(w_b_win[2*i+2 -: 3]);

        booth_pp_row #(.WIDTH(WIDTH)) u_pp_row (
            .digit    (w_dig),
            .a        (r_a1),
            .a_signed (r_sgn1),
            .row      (w_pp[i]),
            .neg      (w_neg[i])
        );
    end

    always_comb begin
        w_negrow = '0;
        for (int i = 0; i < c_nrows; i++) w_rows[i] = '0;
        for (int i = 0; i < c_ndig; i++) begin
            w_rows[i] = {{(c_pw-c_ppw){1'b0}}, ~w_pp[i][c_ppw-1], w_pp[i][c_ppw-2:0]} << (2 * i);
            w_negrow[2*i] = w_neg[i];
        end
        w_rows[c_ndig]     = w_negrow;
        w_rows[c_ndig + 1] = c_sign_corr;
`ifdef BOOTH_MULT_ACC_EN
        w_rows[c_ndig + 2] = r_c1;
`endif
    end

    for (genvar r = 0; r < c_nrows; r++) begin : g_lvl0
        assign w_lvl[0][r] = w_rows[r];
    end

    // Wallace-style reduction: each level packs rows in groups of three
    for (genvar l = 0; l < c_nlev; l++) begin : g_lvl
        localparam int c_n  = csa_rows_at(c_nrows, l);
        localparam int c_g  = c_n / 3;
        localparam int c_nn = csa_rows_after(c_n);

        for (genvar g = 0; g < c_g; g++) begin : g_csa
            logic [c_pw-1:0] w_x, w_y, w_z;
            assign w_x = w_lvl[l][3*g];
            assign w_y = w_lvl[l][3*g+1];
            assign w_z = w_lvl[l][3*g+2];
            assign w_lvl[l+1][2*g]   = w_x ^ w_y ^ w_z;
            assign w_lvl[l+1][2*g+1] = {(w_x[c_pw-2:0] & w_y[c_pw-2:0]) |
                                        (w_x[c_pw-2:0] & w_z[c_pw-2:0]) |
                                        (w_y[c_pw-2:0] & w_z[c_pw-2:0]), 1'b0};
        end

        for (genvar r = 0; r < c_n % 3; r++) begin : g_pass
            assign w_lvl[l+1][2*c_g+r] = w_lvl[l][3*c_g+r];
        end

        for (genvar r = c_nn; r < c_nrows; r++) begin : g_zero
            assign w_lvl[l+1][r] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld2 && r_v1) begin
            r_sum2 <= w_lvl[c_nlev][0];
            r_cry2 <= w_lvl[c_nlev][1];
        end
    end

    // ---------------- S3: carry-propagate add ----------------------------
    always_ff @(posedge clk) begin
        if (w_ld3 && r_v2)
            r_p3 <= r_sum2 + r_cry2;
    end

    assign out_valid = r_v3;
    assign out_p     = r_p3;

endmodule

`default_nettype wire

// File: tb/tb_booth_mult_pipe.sv
// ============================================================================
//  Module      : tb_booth_mult_pipe
//  Description : Self-checking bench for booth_mult_pipe: directed table,
//                random streaming, backpressure and mid-flight reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_booth_mult_pipe;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          sgn;
        logic [PW-1:0] p;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_signed = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, out_valid;
    logic [W-1:0]  in_a = '0, in_b = '0;
    logic [PW-1:0] in_c = '0;
    logic [PW-1:0] out_p;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int cyc      = 0;
    int last_out_cyc = -10;
    int streak   = 0;
    int max_streak = 0;
    bit            hold_pending = 1'b0;
    logic [PW-1:0] hold_p = '0;
    logic [PW-1:0] exp_q [$];

    always #5 clk = ~clk;

    booth_mult_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
`ifdef BOOTH_MULT_ACC_EN
        .in_c      (in_c),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sgn, input logic [PW-1:0] c);
        longint sa, sb, r;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        r  = sa * sb + longint'(c);
        return r[PW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and output-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_p", 64'(out_p), 64'(hold_p));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_signed, in_c));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0)
                    check("out_unexpected", 64'(out_valid), 64'd0);
                else
                    check("stream_p", 64'(out_p), 64'(exp_q.pop_front()));
                streak = (cyc == last_out_cyc + 1) ? streak + 1 : 1;
                last_out_cyc = cyc;
                if (streak > max_streak) max_streak = streak;
            end
            hold_pending = out_valid && !out_ready;
            hold_p       = out_p;
        end
    end

    task automatic rand_beat();
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        in_signed = 1'($urandom);
`ifdef BOOTH_MULT_ACC_EN
        in_c      = PW'($urandom);
`endif
        in_valid  = 1'b1;
    endtask

    task automatic apply_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sgn, input logic [PW-1:0] exp);
        @(posedge clk); #1;
        in_a = a; in_b = b; in_signed = sgn; in_c = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_early1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({name, "_early2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_p"}, 64'(out_p), 64'(exp));
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

`ifdef BOOTH_MULT_ACC_EN
    logic          v16 = 1'b0, s16 = 1'b0;
    logic          rdy16, ov16;
    logic [15:0]   a16 = '0, b16 = '0;
    logic [31:0]   c16 = '0, p16;

    booth_mult_pipe #(.WIDTH(16)) dut16 (
        .clk (clk), .rst_n (rst_n), .in_valid (v16), .in_ready (rdy16),
        .in_a (a16), .in_b (b16), .in_signed (s16), .in_c (c16),
        .out_valid (ov16), .out_ready (1'b1), .out_p (p16)
    );

    task automatic acc16(input string name, input logic sgn, input logic [31:0] exp);
        @(posedge clk); #1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 32'h0000_0005; s16 = sgn; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        for (int k = 0; k < 8 && !ov16; k++) @(negedge clk);
        check({name, "_valid"}, 64'(ov16), 64'd1);
        check({name, "_p"}, 64'(p16), 64'(exp));
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        vec_t tbl [10];
        int   n_acc0;
        int   stale;

        tbl[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        tbl[1] = '{8'h7F, 8'hFF, 1'b1, 16'hFF81};
        tbl[2] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        tbl[3] = '{8'h80, 8'h02, 1'b0, 16'h0100};
        tbl[4] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        tbl[5] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        tbl[7] = '{8'h00, 8'hAB, 1'b1, 16'h0000};
        tbl[8] = '{8'hFF, 8'h80, 1'b0, 16'h7F80};
        tbl[9] = '{8'hFF, 8'h80, 1'b1, 16'h0080};

        #1 rst_n = 1'b0;
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            apply_one($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].p);

        // Random mixed-mode streaming, one beat per cycle
        @(posedge clk); #1;
        out_ready  = 1'b1;
        max_streak = 0;
        for (int i = 0; i < 64; i++) begin
            rand_beat();
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain("stream_drain");
        check("stream_back_to_back", 64'(max_streak), 64'd64);

        // Backpressure with streaming input
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_acc0 = n_acc;
        for (int k = 0; k < 5; k++) begin
            rand_beat();
            @(negedge clk);
            check($sformatf("bp_in_ready%0d", k), 64'(in_ready), (k < 3) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
        end
        check("bp_accepts", 64'(n_acc - n_acc0), 64'd3);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        rand_beat();
        @(negedge clk);
        check("bp_full_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_occupancy", 64'(out_valid), 64'd1);
        drain("bp_drain");

        // Reset with three beats in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_beat();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_no_stale", 64'(stale), 64'd0);
        apply_one("post_rst", 8'h80, 8'h80, 1'b1, 16'h4000);

`ifdef BOOTH_MULT_ACC_EN
        acc16("acc16_signed", 1'b1, 32'h0000_0006);
        acc16("acc16_unsigned", 1'b0, 32'hFFFE_0006);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
